lsio_rstgen: RTL and testbench

- System reset sequencer; it sits at the consuming end of the LSIO error/watchdog unit's reset-request line.
- Takes the error unit's reset request, and optionally a debounced push-button, and drives a stretched synchronous system reset `sys_rstn_o`.
- `sys_rstn_o` feeds the core and the error unit's own `rstn_i`.
- Records the last reset cause and a saturating reset count for software readout.

---
 rtl/lsio_pkg.sv | 18 +
 rtl/lsio_debounce.sv | 55 +++++
 rtl/lsio_rstgen.sv | 121 ++++++++++++
 tb/tb_lsio_rstgen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lsio_pkg.sv
// Shared types for the LSIO reset sequencer: FSM state and reset-cause encodings.
package lsio_pkg;

  localparam int unsigned RST_CAUSE_W = 2;

  typedef enum logic [1:0] {
    HOLD,
    SETTLE,
    RUN
  } rstgen_state_e;

  typedef enum logic [RST_CAUSE_W-1:0] {
    RST_CAUSE_POR = 2'd0,
    RST_CAUSE_ERR = 2'd1,
    RST_CAUSE_BTN = 2'd2
  } rst_cause_e;

endpackage

// File: rtl/lsio_debounce.sv
// Push-button conditioner: 2-flop synchronizer, ms-tick stability counter and
// one-cycle press pulse on the rising edge of the debounced state.
module lsio_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic one_ms_event_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // Pressed state flips only after the synchronized input has disagreed with it
  // for DEBOUNCE_MS consecutive ticks; any agreement restarts the count.
  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    if (sync_q[1] == pressed_q) begin
      cnt_d = '0;
    end else if (one_ms_event_i) begin
      if (cnt_q == LAST) begin
        pressed_d = sync_q[1];
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      press_q   <= pressed_d & ~pressed_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lsio_rstgen.sv
// System reset sequencer: stretches error/button reset requests into a
// registered active-low system reset and records cause and count.
// Optional button input enabled by defining LSIO_RSTGEN_BUTTON_EN.
module lsio_rstgen
  import lsio_pkg::*;
#(
  parameter int unsigned HOLD_MS     = 4,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   one_ms_event_i,
  input  logic                   req_reset_i,
  input  logic                   btn_i,
  output logic                   sys_rstn_o,
  output logic [RST_CAUSE_W-1:0] rst_cause_o,
  output logic [CNT_W-1:0]       rst_count_o,
  output logic                   busy_o
);

  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_MS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  rstgen_state_e    state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  rst_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rstn_q, rstn_d;
  logic             busy_q, busy_d;
  logic             btn_press;

`ifdef LSIO_RSTGEN_BUTTON_EN
  lsio_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .one_ms_event_i (one_ms_event_i),
    .btn_i          (btn_i),
    .press_o        (btn_press)
  );
`else
  logic       unused_btn;
  logic [7:0] unused_debounce_ms;
  assign unused_btn         = btn_i;
  assign unused_debounce_ms = 8'(DEBOUNCE_MS);
  assign btn_press          = 1'b0;
`endif

  // Next-state logic; outputs are derived from the next state so they register
  // alongside it.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    settle_cnt_d = settle_cnt_q;
    cause_d      = cause_q;
    count_d      = count_q;
    unique case (state_q)
      HOLD: begin
        if (one_ms_event_i) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d      = SETTLE;
            hold_cnt_d   = '0;
            settle_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = RUN;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req_reset_i || btn_press) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          cause_d    = req_reset_i ? RST_CAUSE_ERR : RST_CAUSE_BTN;
          count_d    = (count_q == '1) ? count_q : count_q + 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    rstn_d = (state_d != HOLD);
    busy_d = (state_d != RUN);
  end

  // State and output registers; rst_i forces the power-on hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      settle_cnt_q <= '0;
      cause_q      <= RST_CAUSE_POR;
      count_q      <= '0;
      rstn_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
      rstn_q       <= rstn_d;
      busy_q       <= busy_d;
    end
  end

  assign sys_rstn_o  = rstn_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = count_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_lsio_rstgen.sv
// Directed self-checking bench for lsio_rstgen (HOLD_MS=4, SETTLE_CYC=4,
// CNT_W=2). Button scenarios run only when LSIO_RSTGEN_BUTTON_EN is defined.
module tb_lsio_rstgen;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       one_ms_event_i = 1'b0;
  logic       req_reset_i = 1'b0;
  logic       btn_i = 1'b0;
  logic       sys_rstn_o;
  logic [1:0] rst_cause_o;
  logic [1:0] rst_count_o;
  logic       busy_o;

  int total = 0;
  int fails = 0;
  int falls = 0;
  logic prev_rstn = 1'b0;

  lsio_rstgen #(
    .HOLD_MS     (4),
    .SETTLE_CYC  (4),
    .CNT_W       (2),
    .DEBOUNCE_MS (20)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .one_ms_event_i (one_ms_event_i),
    .req_reset_i    (req_reset_i),
    .btn_i          (btn_i),
    .sys_rstn_o     (sys_rstn_o),
    .rst_cause_o    (rst_cause_o),
    .rst_count_o    (rst_count_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Count sys_rstn_o falling edges to catch extra or missing resets.
  always @(negedge clk_i) begin
    if (prev_rstn && !sys_rstn_o) falls++;
    prev_rstn = sys_rstn_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // n ms ticks, each preceded by 9 idle cycles.
  task automatic ms_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) cyc();
      one_ms_event_i = 1'b1;
      cyc();
      one_ms_event_i = 1'b0;
    end
  endtask

  // Full 4-tick hold followed by 4-cycle settle, checked along the way.
  task automatic hold_seq(input string tag);
    for (int t = 1; t <= 3; t++) begin
      ms_ticks(1);
      chk({tag, "_hold_rstn"}, 32'(sys_rstn_o), 32'd0);
    end
    ms_ticks(1);
    chk({tag, "_release_rstn"}, 32'(sys_rstn_o), 32'd1);
    chk({tag, "_settle_busy"}, 32'(busy_o), 32'd1);
    repeat (3) cyc();
    chk({tag, "_settle_busy3"}, 32'(busy_o), 32'd1);
    cyc();
    chk({tag, "_run_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_run_rstn"}, 32'(sys_rstn_o), 32'd1);
  endtask

  task automatic err_reset(input string tag, input logic [1:0] exp_cnt);
    req_reset_i = 1'b1;
    cyc();
    req_reset_i = 1'b0;
    chk({tag, "_rstn"}, 32'(sys_rstn_o), 32'd0);
    chk({tag, "_cause"}, 32'(rst_cause_o), 32'd1);
    chk({tag, "_count"}, 32'(rst_count_o), 32'(exp_cnt));
    hold_seq(tag);
  endtask

  initial begin
    int f0;
    // 1. power-on reset
    cyc();
    cyc();
    chk("por_rstn", 32'(sys_rstn_o), 32'd0);
    chk("por_busy", 32'(busy_o), 32'd1);
    chk("por_cause", 32'(rst_cause_o), 32'd0);
    chk("por_count", 32'(rst_count_o), 32'd0);
    rst_i = 1'b0;
    hold_seq("por");
    chk("por_cause_after", 32'(rst_cause_o), 32'd0);
    chk("por_count_after", 32'(rst_count_o), 32'd0);

    // 2. error request, then re-raise during SETTLE is ignored
    req_reset_i = 1'b1;
    cyc();
    req_reset_i = 1'b0;
    chk("err_rstn", 32'(sys_rstn_o), 32'd0);
    chk("err_cause", 32'(rst_cause_o), 32'd1);
    chk("err_count", 32'(rst_count_o), 32'd1);
    ms_ticks(3);
    chk("err_hold3", 32'(sys_rstn_o), 32'd0);
    ms_ticks(1);
    chk("err_release", 32'(sys_rstn_o), 32'd1);
    req_reset_i = 1'b1;
    cyc();
    cyc();
    chk("settle_req_ignored", 32'(sys_rstn_o), 32'd1);
    req_reset_i = 1'b0;
    cyc();
    cyc();
    chk("settle_done_busy", 32'(busy_o), 32'd0);
    cyc();
    chk("settle_req_rstn", 32'(sys_rstn_o), 32'd1);
    chk("settle_req_count", 32'(rst_count_o), 32'd1);

    // 5. saturation at CNT_W = 2
    err_reset("sat2", 2'd2);
    err_reset("sat3", 2'd3);
    err_reset("sat4", 2'd3);
    err_reset("sat5", 2'd3);

    // 6. rst_i mid-HOLD restarts full hold with cleared cause/count
    req_reset_i = 1'b1;
    cyc();
    req_reset_i = 1'b0;
    ms_ticks(2);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("midrst_rstn", 32'(sys_rstn_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd1);
    chk("midrst_cause", 32'(rst_cause_o), 32'd0);
    chk("midrst_count", 32'(rst_count_o), 32'd0);
    hold_seq("midrst");

`ifdef LSIO_RSTGEN_BUTTON_EN
    // 3. request coincides with the debounced press pulse
    f0 = falls;
    btn_i = 1'b1;
    ms_ticks(19);
    repeat (9) cyc();
    one_ms_event_i = 1'b1;
    cyc();
    one_ms_event_i = 1'b0;
    req_reset_i = 1'b1;
    cyc();
    req_reset_i = 1'b0;
    chk("sim_rstn", 32'(sys_rstn_o), 32'd0);
    chk("sim_cause", 32'(rst_cause_o), 32'd1);
    chk("sim_count", 32'(rst_count_o), 32'd1);
    ms_ticks(10);
    btn_i = 1'b0;
    ms_ticks(25);
    chk("sim_single_reset", 32'(falls - f0), 32'd1);
    chk("sim_count_after", 32'(rst_count_o), 32'd1);

    // 4. bounce then steady press
    f0 = falls;
    for (int k = 0; k < 10; k++) begin
      btn_i = ~btn_i;
      ms_ticks(3);
    end
    btn_i = 1'b0;
    chk("bounce_no_reset", 32'(falls - f0), 32'd0);
    btn_i = 1'b1;
    ms_ticks(25);
    chk("btn_one_reset", 32'(falls - f0), 32'd1);
    chk("btn_cause", 32'(rst_cause_o), 32'd2);
    chk("btn_count", 32'(rst_count_o), 32'd2);
    chk("btn_run_rstn", 32'(sys_rstn_o), 32'd1);
    ms_ticks(25);
    chk("btn_held_no_second", 32'(falls - f0), 32'd1);
    btn_i = 1'b0;
`else
    f0 = falls;
    btn_i = 1'b1;
    ms_ticks(30);
    chk("btn_disabled_no_reset", 32'(falls - f0), 32'd0);
    chk("btn_disabled_cause", 32'(rst_cause_o), 32'd0);
    btn_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
